// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage request controller:
// state encoding, bus widths, the held-request record and a small address helper.
package mem_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    localparam int unsigned MEM_AW      = 16;
    localparam int unsigned MEM_DW      = 16;
    localparam int unsigned TIMEOUT_DEF = 64;

    // One in-flight request as seen by the memory: 1 + 16 + 16 = 33 bits
    typedef struct packed {
        logic              wr;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] wdata;
    } hold_t;

    // Halfword accesses must sit on an even byte address
    function automatic logic is_aligned(input logic [MEM_AW-1:0] addr);
        return ~addr[0];
    endfunction

endpackage

// File: rtl/mem_req_hold.sv
// Enable-loaded hold register for the in-flight request, cleared by the
// synchronous active-low reset so a stale store can never be replayed.
module mem_req_hold
    import mem_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  hold_t din,
    output hold_t dout
);

    hold_t hold_r;

    // Capture the request on issue, otherwise keep it stable
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_r <= '0;
        end else if (load) begin
            hold_r <= din;
        end else begin
            hold_r <= hold_r;
        end
    end

    assign dout = hold_r;

endmodule

// File: rtl/mem_req_ctrl.sv
// Memory-stage request controller: issues one load/store to a stalling memory,
// holds it stable until Done, and reports read data, errors or watchdog aborts.
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [MEM_AW-1:0] req_addr,
    input  logic [MEM_DW-1:0] req_wdata,
    output logic              stall_pipe,
    output logic              resp_valid,
    output logic [MEM_DW-1:0] resp_rdata,
    output logic              resp_err,
    output logic              resp_timeout,
    output logic [MEM_DW-1:0] last_rdata,
    output logic              mem_Rd,
    output logic              mem_Wr,
    output logic [MEM_AW-1:0] mem_Addr,
    output logic [MEM_DW-1:0] mem_DataIn,
    input  logic [MEM_DW-1:0] mem_DataOut,
    input  logic              mem_Done,
    input  logic              mem_Stall,
    input  logic              mem_err
);

    localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    logic              state_r;
    logic              state_nxt_s;
    logic [CNT_W-1:0]  wd_r;
    logic [CNT_W-1:0]  wd_nxt_s;
    logic [MEM_DW-1:0] last_rdata_r;
    hold_t             hold_din_s;
    hold_t             hold_q_s;
    logic              hold_load_s;
    logic              issue_s;
    logic              clean_ld_s;
    logic              rd_s;
    logic              wr_s;
    logic              stall_s;
    logic              rv_s;
    logic              err_s;
    logic              tmo_s;
    logic [MEM_AW-1:0] addr_s;
    logic [MEM_DW-1:0] din_s;
    logic [MEM_DW-1:0] rdata_s;
    logic              mem_stall_unused_s;

    // Absence of mem_Done alone keeps a request in flight
    assign mem_stall_unused_s = mem_Stall;

    assign issue_s    = (state_r == ST_IDLE) & req_valid & is_aligned(req_addr);
    assign hold_din_s = '{wr: req_wr, addr: req_addr, wdata: req_wdata};

    mem_req_hold u_hold (
        .clk  (clk),
        .rst  (rst),
        .load (hold_load_s),
        .din  (hold_din_s),
        .dout (hold_q_s)
    );

    // State, watchdog and last-load registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            wd_r         <= '0;
            last_rdata_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            wd_r    <= wd_nxt_s;
            if (clean_ld_s) begin
                last_rdata_r <= mem_DataOut;
            end else begin
                last_rdata_r <= last_rdata_r;
            end
        end
    end

    // Next state, watchdog count and hold-register capture
    always_comb begin
        state_nxt_s = state_r;
        wd_nxt_s    = wd_r;
        hold_load_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (issue_s && !mem_Done) begin
                    state_nxt_s = ST_WAIT;
                    wd_nxt_s    = ONE_C;
                    hold_load_s = 1'b1;
                end else begin
                    wd_nxt_s = '0;
                end
            end
            ST_WAIT: begin
                if (mem_Done || (wd_r >= TMO_C)) begin
                    state_nxt_s = ST_IDLE;
                    wd_nxt_s    = '0;
                end else begin
                    wd_nxt_s = wd_r + ONE_C;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                wd_nxt_s    = '0;
            end
        endcase
    end

    // Memory strobes, pipeline stall and response; IDLE drives from req_*, WAIT from the hold copy
    always_comb begin
        rd_s       = 1'b0;
        wr_s       = 1'b0;
        stall_s    = 1'b0;
        rv_s       = 1'b0;
        err_s      = 1'b0;
        tmo_s      = 1'b0;
        clean_ld_s = 1'b0;
        addr_s     = '0;
        din_s      = '0;
        rdata_s    = '0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid && !is_aligned(req_addr)) begin
                    rv_s  = 1'b1;
                    err_s = 1'b1;
                end else if (issue_s) begin
                    rd_s   = ~req_wr;
                    wr_s   = req_wr;
                    addr_s = req_addr;
                    din_s  = req_wdata;
                    if (mem_Done) begin
                        rv_s       = 1'b1;
                        err_s      = mem_err;
                        rdata_s    = req_wr ? '0 : mem_DataOut;
                        clean_ld_s = ~req_wr & ~mem_err;
                    end else begin
                        stall_s = 1'b1;
                    end
                end else begin
                    stall_s = 1'b0;
                end
            end
            ST_WAIT: begin
                addr_s = hold_q_s.addr;
                din_s  = hold_q_s.wdata;
                if (mem_Done) begin
                    rd_s       = ~hold_q_s.wr;
                    wr_s       = hold_q_s.wr;
                    rv_s       = 1'b1;
                    err_s      = mem_err;
                    rdata_s    = hold_q_s.wr ? '0 : mem_DataOut;
                    clean_ld_s = ~hold_q_s.wr & ~mem_err;
                end else if (wd_r >= TMO_C) begin
                    rv_s  = 1'b1;
                    err_s = 1'b1;
                    tmo_s = 1'b1;
                end else begin
                    rd_s    = ~hold_q_s.wr;
                    wr_s    = hold_q_s.wr;
                    stall_s = 1'b1;
                end
            end
            default: begin
                stall_s = 1'b0;
            end
        endcase
    end

    // Reset forces strobes and handshakes low immediately, without waiting for the edge
    assign mem_Rd       = rst & rd_s;
    assign mem_Wr       = rst & wr_s;
    assign stall_pipe   = rst & stall_s;
    assign resp_valid   = rst & rv_s;
    assign resp_err     = rst & err_s;
    assign resp_timeout = rst & tmo_s;
    assign resp_rdata   = {MEM_DW{rst}} & rdata_s;
    assign mem_Addr     = addr_s;
    assign mem_DataIn   = din_s;
    assign last_rdata   = last_rdata_r;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_mem_req_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        stall_pipe;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic        resp_timeout;
    logic [15:0] last_rdata;
    logic        mem_Rd;
    logic        mem_Wr;
    logic [15:0] mem_Addr;
    logic [15:0] mem_DataIn;
    logic [15:0] mem_DataOut;
    logic        mem_Done;
    logic        mem_Stall;
    logic        mem_err;

    int total = 0;
    int bad   = 0;

    // Reference model: one outstanding request and how long it has stalled the pipe
    logic        m_busy    = 1'b0;
    logic        m_wr      = 1'b0;
    logic [15:0] m_addr    = 16'h0;
    logic [15:0] m_wdata   = 16'h0;
    int          m_stalled = 0;
    logic [15:0] m_last    = 16'h0;

    mem_req_ctrl #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall_pipe   (stall_pipe),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .resp_timeout (resp_timeout),
        .last_rdata   (last_rdata),
        .mem_Rd       (mem_Rd),
        .mem_Wr       (mem_Wr),
        .mem_Addr     (mem_Addr),
        .mem_DataIn   (mem_DataIn),
        .mem_DataOut  (mem_DataOut),
        .mem_Done     (mem_Done),
        .mem_Stall    (mem_Stall),
        .mem_err      (mem_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%04h expected 0x%04h", tag, $time, got, exp);
        end
    endtask

    // One clock: drive inputs, check combinational outputs against the model, advance
    task automatic step(input logic r, input logic v, input logic w,
                        input logic [15:0] a, input logic [15:0] wd,
                        input logic dn, input logic st, input logic er,
                        input logic [15:0] dout);
        logic        e_rd, e_wr, e_stall, e_rv, e_err, e_tmo;
        logic [15:0] e_addr, e_din, e_rdata;
        logic        n_busy, n_wr;
        logic [15:0] n_addr, n_wdata, n_last;
        int          n_stalled;
        @(negedge clk);
        rst = r; req_valid = v; req_wr = w; req_addr = a; req_wdata = wd;
        mem_Done = dn; mem_Stall = st; mem_err = er; mem_DataOut = dout;
        #1;
        e_rd = 1'b0; e_wr = 1'b0; e_stall = 1'b0; e_rv = 1'b0; e_err = 1'b0; e_tmo = 1'b0;
        e_addr = 16'h0; e_din = 16'h0; e_rdata = 16'h0;
        n_busy = m_busy; n_wr = m_wr; n_addr = m_addr; n_wdata = m_wdata;
        n_stalled = m_stalled; n_last = m_last;
        if (!r) begin
            n_busy = 1'b0; n_stalled = 0; n_last = 16'h0;
        end else if (!m_busy) begin
            if (v && a[0]) begin
                e_rv = 1'b1; e_err = 1'b1;
            end else if (v) begin
                e_rd = !w; e_wr = w; e_addr = a; e_din = wd;
                if (dn) begin
                    e_rv = 1'b1; e_err = er; e_rdata = w ? 16'h0 : dout;
                    if (!w && !er) n_last = dout;
                end else begin
                    e_stall = 1'b1; n_busy = 1'b1; n_stalled = 1;
                    n_wr = w; n_addr = a; n_wdata = wd;
                end
            end
        end else begin
            if (dn) begin
                e_rd = !m_wr; e_wr = m_wr; e_addr = m_addr; e_din = m_wdata;
                e_rv = 1'b1; e_err = er; e_rdata = m_wr ? 16'h0 : dout;
                if (!m_wr && !er) n_last = dout;
                n_busy = 1'b0;
            end else if (m_stalled == TMO) begin
                e_rv = 1'b1; e_err = 1'b1; e_tmo = 1'b1; n_busy = 1'b0;
            end else begin
                e_rd = !m_wr; e_wr = m_wr; e_addr = m_addr; e_din = m_wdata;
                e_stall = 1'b1; n_stalled = m_stalled + 1;
            end
        end
        check_val("stall_pipe", stall_pipe, e_stall);
        check_val("resp_valid", resp_valid, e_rv);
        check_val("resp_err", resp_err, e_err);
        check_val("resp_timeout", resp_timeout, e_tmo);
        check_val("resp_rdata", resp_rdata, e_rdata);
        check_val("mem_Rd", mem_Rd, e_rd);
        check_val("mem_Wr", mem_Wr, e_wr);
        if (e_rd || e_wr) begin
            check_val("mem_Addr", mem_Addr, e_addr);
            check_val("mem_DataIn", mem_DataIn, e_din);
        end
        @(posedge clk);
        #1;
        m_busy = n_busy; m_wr = n_wr; m_addr = n_addr; m_wdata = n_wdata;
        m_stalled = n_stalled; m_last = n_last;
        check_val("last_rdata", last_rdata, m_last);
    endtask

    initial begin
        int dead;
        logic        v, w, dn, st, er, r;
        logic [15:0] a;
        rst = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
        mem_DataOut = 16'h0; mem_Done = 1'b0; mem_Stall = 1'b0; mem_err = 1'b0;

        // Reset state, with request and memory activity that must be ignored
        step(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 1'b0, 16'hFFFF);
        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        check_val("reset_last", last_rdata, 16'h0000);

        // Zero-latency load
        step(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 1'b0, 16'hBEEF);
        check_val("ld_imm_last", last_rdata, 16'hBEEF);

        // Store held through three stall cycles while the pipeline address changes
        step(1'b1, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b1, 16'h0040, 16'h9999, 1'b0, 1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b1, 16'h0040, 16'h9999, 1'b0, 1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b1, 16'h0040, 16'h9999, 1'b1, 1'b0, 1'b0, 16'h7777);
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);

        // Misaligned load
        step(1'b1, 1'b1, 1'b0, 16'h0011, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);

        // Watchdog abort: four stalled cycles, then the abort cycle
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
        end
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);

        // Memory error on a load leaves last_rdata alone
        step(1'b1, 1'b1, 1'b0, 16'h0050, 16'h0, 1'b1, 1'b0, 1'b1, 16'hDEAD);
        check_val("err_last_kept", last_rdata, 16'hBEEF);

        // Reset on the second stall cycle, then a normal load
        step(1'b1, 1'b1, 1'b0, 16'h0060, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b0, 16'h0060, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0, 1'b1, 1'b0, 1'b0, 16'h5A5A);
        check_val("post_rst_last", last_rdata, 16'h5A5A);

        // Random traffic including dead-memory stretches and occasional reset
        dead = 0;
        for (int i = 0; i < 3000; i++) begin
            if (dead == 0 && $urandom_range(0, 39) == 0) dead = $urandom_range(3, 8);
            r  = ($urandom_range(0, 99) != 0);
            v  = ($urandom_range(0, 3) != 0);
            w  = $urandom_range(0, 1) == 1;
            a  = 16'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 7) == 0) a = a | 16'h0001;
            if (dead > 0) begin
                dn = 1'b0;
                dead--;
            end else begin
                dn = ($urandom_range(0, 2) == 0);
            end
            st = dn ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 4) != 0);
            er = ($urandom_range(0, 5) == 0);
            step(r, v, w, a, 16'($urandom), dn, st, er, 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Memory-stage request controller that sits directly upstream of the stalling memory (data or instruction side).
- Accepts one load/store per request from the pipeline and drives the memory's Rd/Wr/Addr/DataIn.
- Holds the request stable across memory Stall cycles, stalls the pipeline until Done, then returns read data or an error.
- Misaligned accesses are rejected locally; a watchdog aborts requests the memory never completes.

Parameters:
- TIMEOUT, 64, wait cycles allowed in WAIT before abort; legal range 2..255.
- CNT_W, 8, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low (rst=0 resets on the rising clk edge)
- req_valid  in  1  pipeline presents a memory op this cycle
- req_wr  in  1  1=store, 0=load (meaningful only with req_valid)
- req_addr  in  16  byte address
- req_wdata  in  16  store data
- stall_pipe  out  1  pipeline must hold its request and its stage
- resp_valid  out  1  one-cycle pulse: request completed or aborted
- resp_rdata  out  16  load data, valid with resp_valid & ~resp_err & load
- resp_err  out  1  with resp_valid: misaligned, memory err, or timeout
- resp_timeout  out  1  with resp_valid: abort was caused by the watchdog
- last_rdata  out  16  registered copy of the most recent successful load data
- mem_Rd  out  1  memory read strobe
- mem_Wr  out  1  memory write strobe
- mem_Addr  out  16  memory address
- mem_DataIn  out  16  memory write data
- mem_DataOut  in  16  memory read data, valid when mem_Done
- mem_Done  in  1  memory completed the access this cycle
- mem_Stall  in  1  memory busy; access did not occur
- mem_err  in  1  memory error, qualified by mem_Done

Behaviour:
- States: IDLE, WAIT.
- Reset: state=IDLE, hold registers=0, watchdog=0, last_rdata=0.
  - Outputs while rst=0: stall_pipe=0, resp_valid=0, resp_err=0, resp_timeout=0, mem_Rd=mem_Wr=0.
- IDLE, req_valid=0: all strobes 0, stall_pipe=0.
- IDLE, req_valid=1, req_addr[0]=1 (misaligned):
  - No memory strobe.
  - resp_valid=1, resp_err=1, stall_pipe=0 in the same cycle; stay in IDLE.
- IDLE, req_valid=1, aligned:
  - Issue combinationally from the req_* inputs: mem_Rd=~req_wr, mem_Wr=req_wr, mem_Addr=req_addr, mem_DataIn=req_wdata.
  - Same-cycle mem_Done: zero-latency completion.
    - resp_valid=1, resp_rdata=mem_DataOut, resp_err=mem_err, stall_pipe=0.
    - Stay in IDLE.
    - On a load without error, last_rdata<=mem_DataOut.
  - No mem_Done: stall_pipe=1; capture req_wr/req_addr/req_wdata into the hold registers; watchdog<=1; go to WAIT.
- WAIT:
  - Memory is driven only from the hold registers; req_* inputs are ignored, so later pipeline changes cannot corrupt an in-flight store.
  - stall_pipe=1 every cycle except the completion cycle.
  - mem_Done: resp_valid=1, resp_rdata=mem_DataOut, resp_err=mem_err, stall_pipe=0; last_rdata updates on a clean load; go to IDLE.
  - Completion frees the pipeline that cycle; the next request is not issued until the following cycle (one bubble).
  - Not done, watchdog==TIMEOUT: drop strobes that cycle; resp_valid=1, resp_err=1, resp_timeout=1, stall_pipe=0; go to IDLE.
  - Otherwise: watchdog increments and saturates at TIMEOUT.
- mem_Stall is informational only: absence of mem_Done is what keeps the request in flight. mem_Done and mem_Stall both high is treated as Done.
- mem_err is honoured only when mem_Done=1.
- resp_rdata=0 whenever resp_valid=0, and for stores.
- rst=0 mid-WAIT: the request is abandoned; strobes drop at once (the reset path is combinational on the strobes); no resp_valid.

Decomposition:
- Shared package mem_pkg:
  - State encoding localparams ST_IDLE=1'b0, ST_WAIT=1'b1.
  - MEM_AW=16, MEM_DW=16.
  - Default TIMEOUT value.
- Sub-module mem_req_hold: enable-loaded 33-bit hold register (wr, addr, wdata) with synchronous active-low clear. Keeps the top file to FSM, mux and watchdog.

Test Plan:
- Load, memory ready immediately: addr=0x0010, mem_DataOut=0xBEEF, mem_Done same cycle -> resp_valid=1, resp_rdata=0xBEEF, stall_pipe=0, last_rdata=0xBEEF next cycle.
- Store with 3 stall cycles: addr=0x0020, wdata=0x1234; bench changes req_addr to 0x0040 after the first cycle -> mem_Addr stays 0x0020 and mem_DataIn stays 0x1234 throughout; stall_pipe=1 for 3 cycles; resp_valid on the 4th cycle.
- Misaligned load: addr=0x0011 -> mem_Rd=0, resp_valid=1, resp_err=1 same cycle, FSM stays IDLE.
- Timeout with TIMEOUT=4 and mem_Done never asserted -> stall_pipe high for 4 cycles; 5th cycle resp_valid=1, resp_err=1, resp_timeout=1; strobes 0.
- Memory error: mem_Done=1 with mem_err=1 on a load -> resp_err=1, last_rdata unchanged.
- Reset mid-WAIT: rst=0 on the 2nd stall cycle -> next cycle IDLE, mem_Rd=mem_Wr=0, no resp_valid; a subsequent load to 0x0002 completes normally.
